// File: rtl/iprf_wb_arb_if.sv
// rtl/iprf_wb_arb_if.sv - source push and PRF write-port bundle for iprf_wb_arb
interface iprf_wb_arb_if #(
  parameter int NUM_SRC = 2,
  parameter int PKT_W   = 96,
  parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC-1:0]       src_valid;
  logic [NUM_SRC*PKT_W-1:0] src_pkt;
  logic [NUM_SRC-1:0]       src_ready;
  logic                     nuke;
  logic                     wr_stall;
  logic                     wr_valid;
  logic [PKT_W-1:0]         wr_pkt;
  logic [SRC_W-1:0]         wr_src;
  logic                     busy;

  modport master (
    output src_valid, src_pkt, nuke, wr_stall,
    input  src_ready, wr_valid, wr_pkt, wr_src, busy
  );

  modport slave (
    input  src_valid, src_pkt, nuke, wr_stall,
    output src_ready, wr_valid, wr_pkt, wr_src, busy
  );
endinterface

// File: rtl/iprf_wb_arb.sv
// rtl/iprf_wb_arb.sv - round-robin integer-PRF write-back arbiter; optional same-cycle bypass via IPRF_WB_BYPASS_EN
module iprf_wb_arb #(
  parameter int NUM_SRC    = 2,
  parameter int PKT_W      = 96,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  iprf_wb_arb_if.slave bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  logic [PKT_W-1:0] mem_q [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] head_q [NUM_SRC];
  logic [PTR_W-1:0] head_d [NUM_SRC];
  logic [PTR_W-1:0] tail_q [NUM_SRC];
  logic [PTR_W-1:0] tail_d [NUM_SRC];
  logic [CNT_W-1:0] cnt_q  [NUM_SRC];
  logic [CNT_W-1:0] cnt_d  [NUM_SRC];

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wr_valid_q, wr_valid_d;
  logic [PKT_W-1:0] wr_pkt_q, wr_pkt_d;
  logic [SRC_W-1:0] wr_src_q, wr_src_d;

  logic [NUM_SRC-1:0] ready, nonempty, cand, push, pop;
  logic               out_free, gnt_vld, gnt_byp;
  logic [SRC_W-1:0]   gnt_idx;

  // Ready comes from registered count only, so a full FIFO stays not-ready while popping.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      ready[i]    = (cnt_q[i] != FULL) & ~bus.nuke;
      cand[i]     = nonempty[i];
`ifdef IPRF_WB_BYPASS_EN
      cand[i]     = nonempty[i] | (bus.src_valid[i] & ready[i]);
`endif
    end
  end

  // Scan from rr_ptr upward; iterating downward lets the closest candidate win.
  always_comb begin
    int idx;
    idx      = 0;
    out_free = ~wr_valid_q | ~bus.wr_stall;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
    gnt_vld = gnt_vld & out_free;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wr_valid_d = wr_valid_q;
    wr_pkt_d   = wr_pkt_q;
    wr_src_d   = wr_src_q;
    gnt_byp    = 1'b0;
    pop        = '0;
    push       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      cnt_d[i]  = cnt_q[i];
    end

    if (out_free) begin
      wr_valid_d = gnt_vld;
      if (gnt_vld) begin
        wr_src_d = gnt_idx;
        rr_ptr_d = (int'(gnt_idx) == NUM_SRC - 1) ? '0 : gnt_idx + 1'b1;
        if (nonempty[gnt_idx]) begin
          pop[gnt_idx] = 1'b1;
          wr_pkt_d     = mem_q[gnt_idx][head_q[gnt_idx]];
        end
`ifdef IPRF_WB_BYPASS_EN
        else begin
          gnt_byp  = 1'b1;
          wr_pkt_d = bus.src_pkt[int'(gnt_idx)*PKT_W +: PKT_W];
        end
`endif
      end
    end

    for (int i = 0; i < NUM_SRC; i++) begin
      push[i] = bus.src_valid[i] & ready[i] & ~(gnt_byp & (gnt_idx == SRC_W'(i)));
      if (push[i]) tail_d[i] = tail_q[i] + 1'b1;
      if (pop[i])  head_d[i] = head_q[i] + 1'b1;
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end

    // Nuke overrides stall and discards this cycle's pushes and grant.
    if (bus.nuke) begin
      wr_valid_d = 1'b0;
      rr_ptr_d   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        head_d[i] = '0;
        tail_d[i] = '0;
        cnt_d[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_pkt_q   <= '0;
      wr_src_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_pkt_q   <= wr_pkt_d;
      wr_src_q   <= wr_src_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem_q[i][tail_q[i]] <= bus.src_pkt[i*PKT_W +: PKT_W];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && !bus.nuke)
      assert ((bus.src_valid & ~ready) == '0)
        else $error("iprf_wb_arb: src_valid asserted while src_ready low");
  end
`endif

  assign bus.src_ready = ready;
  assign bus.wr_valid  = wr_valid_q;
  assign bus.wr_pkt    = wr_pkt_q;
  assign bus.wr_src    = wr_src_q;
  assign bus.busy      = wr_valid_q | (|nonempty);
endmodule

// File: tb/tb_iprf_wb_arb.sv
// tb/tb_iprf_wb_arb.sv - randomized bench for iprf_wb_arb against a queue-level reference model
module tb_iprf_wb_arb;
  localparam int NUM_SRC = 2;
  localparam int PKT_W   = 96;
  localparam int DEPTH   = 4;
`ifdef IPRF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef logic [PKT_W-1:0] pkt_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iprf_wb_arb_if #(.NUM_SRC(NUM_SRC), .PKT_W(PKT_W)) bus ();

  iprf_wb_arb #(.NUM_SRC(NUM_SRC), .PKT_W(PKT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pkt_t q [NUM_SRC][$];
  bit   m_valid;
  pkt_t m_pkt;
  int   m_src;
  int   m_rr;

  bit [NUM_SRC-1:0] sv;
  pkt_t             sp [NUM_SRC];
  bit               nk, st, rs;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic pkt_t rnd_pkt();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic model_step();
    bit [NUM_SRC-1:0] rdy;
    int g, j, byp;
    if (rs || nk) begin
      for (int i = 0; i < NUM_SRC; i++) q[i].delete();
      m_valid = 1'b0;
      m_rr    = 0;
      if (rs) begin
        m_pkt = '0;
        m_src = 0;
      end
      return;
    end
    for (int i = 0; i < NUM_SRC; i++) rdy[i] = (q[i].size() < DEPTH);
    byp = -1;
    if (!m_valid || !st) begin
      g = -1;
      for (int k = 0; k < NUM_SRC; k++) begin
        j = (m_rr + k) % NUM_SRC;
        if (g < 0 && (q[j].size() > 0 || (BYP && sv[j] && rdy[j]))) g = j;
      end
      if (g >= 0) begin
        if (q[g].size() > 0) m_pkt = q[g].pop_front();
        else begin
          m_pkt = sp[g];
          byp   = g;
        end
        m_valid = 1'b1;
        m_src   = g;
        m_rr    = (g + 1) % NUM_SRC;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < NUM_SRC; i++)
      if (sv[i] && rdy[i] && i != byp) q[i].push_back(sp[i]);
  endtask

  task automatic compare();
    bit [NUM_SRC-1:0] exp_rdy;
    bit exp_busy;
    exp_busy = m_valid;
    for (int i = 0; i < NUM_SRC; i++) begin
      exp_rdy[i] = (q[i].size() < DEPTH) && !nk;
      if (q[i].size() > 0) exp_busy = 1'b1;
    end
    chk("wr_valid", bus.wr_valid, m_valid);
    chk("busy", bus.busy, exp_busy);
    chk("src_ready", bus.src_ready, exp_rdy);
    if (m_valid) begin
      chk("wr_pkt", bus.wr_pkt, m_pkt);
      chk("wr_src", bus.wr_src, m_src);
    end
  endtask

  // Masks pushes the protocol forbids, except in nuke cycles where they are discarded anyway.
  task automatic cycle();
    for (int i = 0; i < NUM_SRC; i++)
      if (!nk && !rs && q[i].size() >= DEPTH) sv[i] = 1'b0;
    bus.src_valid = sv;
    for (int i = 0; i < NUM_SRC; i++) bus.src_pkt[i*PKT_W +: PKT_W] = sp[i];
    bus.nuke     = nk;
    bus.wr_stall = st;
    reset        = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    sv = '0;
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic single_push();
    sv = 2'b01; sp[0] = pkt_t'(8'hA1); cycle();
    chk("lat_first", bus.wr_valid, BYP);
    sv = '0; cycle();
    chk("lat_second", bus.wr_valid, !BYP);
    idle(2);
    chk("single_busy", bus.busy, 1'b0);
  endtask

  initial begin
    sv = '0; nk = 0; st = 0; rs = 1;
    for (int i = 0; i < NUM_SRC; i++) sp[i] = '0;
    cycle();
    chk("rst_wr_pkt", bus.wr_pkt, '0);
    chk("rst_wr_src", bus.wr_src, '0);
    rs = 0;
    single_push();

    for (int c = 0; c < 8; c++) begin
      sv = 2'b11; sp[0] = rnd_pkt(); sp[1] = rnd_pkt(); cycle();
    end
    idle(12);

    sv = 2'b01; sp[0] = pkt_t'(8'h55); cycle();
    sv = '0; cycle();
    st = 1;
    for (int c = 0; c < 3; c++) begin
      sv = 2'b10; sp[1] = rnd_pkt(); cycle();
    end
    st = 0; idle(6);

    st = 1;
    for (int c = 0; c < 6; c++) begin
      sv = 2'b10; sp[1] = pkt_t'(c + 'h100); cycle();
    end
    chk("full_ready1", bus.src_ready[1], 1'b0);
    st = 0; idle(8);

    st = 1;
    for (int c = 0; c < 4; c++) begin
      sv = 2'b01; sp[0] = rnd_pkt(); cycle();
    end
    nk = 1; sv = 2'b01; sp[0] = pkt_t'(16'hDEAD); cycle();
    nk = 0; sv = '0; cycle();
    chk("nuke_valid", bus.wr_valid, 1'b0);
    chk("nuke_busy", bus.busy, 1'b0);
    chk("nuke_ready", bus.src_ready, 2'b11);
    st = 0; idle(4);

    st = 1;
    for (int c = 0; c < 3; c++) begin
      sv = 2'b11; sp[0] = rnd_pkt(); sp[1] = rnd_pkt(); cycle();
    end
    rs = 1; sv = '0; cycle();
    chk("midrst_wr_pkt", bus.wr_pkt, '0);
    chk("midrst_busy", bus.busy, 1'b0);
    rs = 0; st = 0;
    single_push();

    for (int c = 0; c < 3000; c++) begin
      sv = NUM_SRC'($urandom);
      for (int i = 0; i < NUM_SRC; i++) sp[i] = rnd_pkt();
      st = ($urandom_range(0, 9) < 3);
      nk = ($urandom_range(0, 99) < 2);
      rs = ($urandom_range(0, 99) < 1);
      cycle();
    end
    nk = 0; rs = 0; st = 0;
    idle(10);
    chk("final_busy", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
